// File: rtl/imem_loader.sv
// imem_loader: receives a byte-framed program image, writes it into the CPU
// instruction memory one 9-bit word at a time, then releases the CPU from
// reset and counts its run cycles until it reports halt.
//
// Stream format: HDR_LO, HDR_HI (count N = {HDR_HI[3:0], HDR_LO}), then N
// pairs of (INS_LO, INS_HI) where INS_HI carries only bit 8 of the word.
// All outputs come straight from flops; the handshake/strobe flops are loaded
// from the next-state decode so they line up with the state register.
module imem_loader #(
  parameter int D  = 12,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          imem_we,
  output logic [D-1:0]  imem_addr,
  output logic [8:0]    imem_wdata,
  output logic          cpu_reset,
  input  logic          cpu_done,
  output logic          finished,
  output logic [CW-1:0] cycle_count,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_LO = 3'd1,
    HDR_HI = 3'd2,
    INS_LO = 3'd3,
    INS_HI = 3'd4,
    WR     = 3'd5,
    RUN    = 3'd6,
    FIN    = 3'd7
  } state_t;

  // Largest instruction count the address space can hold without the index
  // wrapping; the 12-bit header field is the other natural limit.
  localparam logic [31:0] NMAX = (D >= 12) ? 32'd4095 : ((32'd1 << D) - 32'd1);

  state_t          state_q, state_d;
  logic [D-1:0]    index_q, index_d;
  logic [D-1:0]    last_q, last_d;
  logic [7:0]      hdr_lo_q, hdr_lo_d;
  logic [8:0]      wdata_q, wdata_d;
  logic [CW-1:0]   cc_q, cc_d;
  logic            fin_q, fin_d;
  logic            err_q, err_d;
  logic            in_ready_q, in_ready_d;
  logic            we_q, we_d;
  logic            cpu_rst_q, cpu_rst_d;

  logic            accept_s;
  logic [11:0]     hdr_n_s;
  logic            n_too_big_s;

  assign accept_s    = in_valid && in_ready_q;
  assign hdr_n_s     = {in_data[3:0], hdr_lo_q};
  assign n_too_big_s = ({20'd0, hdr_n_s} > NMAX);

  // State register and datapath flops; reset forces the idle/hold-CPU state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      index_q    <= {D{1'b0}};
      last_q     <= {D{1'b0}};
      hdr_lo_q   <= 8'd0;
      wdata_q    <= 9'd0;
      cc_q       <= {CW{1'b0}};
      fin_q      <= 1'b0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      cpu_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      last_q     <= last_d;
      hdr_lo_q   <= hdr_lo_d;
      wdata_q    <= wdata_d;
      cc_q       <= cc_d;
      fin_q      <= fin_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  // Next-state, datapath updates and next-cycle output decode.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    last_d     = last_q;
    hdr_lo_d   = hdr_lo_q;
    wdata_d    = wdata_q;
    cc_d       = cc_q;
    fin_d      = fin_q;
    err_d      = err_q;
    in_ready_d = 1'b0;
    we_d       = 1'b0;
    cpu_rst_d  = 1'b1;

    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          fin_d   = 1'b0;
          err_d   = 1'b0;
          cc_d    = {CW{1'b0}};
          index_d = {D{1'b0}};
          state_d = HDR_LO;
        end else begin
          state_d = state_q;
        end
      end
      HDR_LO: begin
        if (accept_s) begin
          hdr_lo_d = in_data;
          state_d  = HDR_HI;
        end else begin
          state_d  = HDR_LO;
        end
      end
      HDR_HI: begin
        if (accept_s) begin
          if ((in_data[7:4] != 4'd0) || (hdr_n_s == 12'd0) || n_too_big_s) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            last_d  = D'(hdr_n_s - 12'd1);
            index_d = {D{1'b0}};
            state_d = INS_LO;
          end
        end else begin
          state_d = HDR_HI;
        end
      end
      INS_LO: begin
        if (accept_s) begin
          wdata_d[7:0] = in_data;
          state_d      = INS_HI;
        end else begin
          state_d      = INS_LO;
        end
      end
      INS_HI: begin
        if (accept_s) begin
          if (in_data[7:1] != 7'd0) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            wdata_d[8] = in_data[0];
            state_d    = WR;
          end
        end else begin
          state_d = INS_HI;
        end
      end
      WR: begin
        // Index stops at N-1, which never exceeds 2^D-2, so it cannot wrap.
        if (index_q == last_q) begin
          state_d = RUN;
        end else begin
          index_d = index_q + {{(D-1){1'b0}}, 1'b1};
          state_d = INS_LO;
        end
      end
      RUN: begin
        if (cpu_done) begin
          fin_d   = 1'b1;
          state_d = FIN;
        end else if (cc_q != {CW{1'b1}}) begin
          cc_d    = cc_q + {{(CW-1){1'b0}}, 1'b1};
          state_d = RUN;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      HDR_LO, HDR_HI, INS_LO, INS_HI: begin
        in_ready_d = 1'b1;
      end
      WR: begin
        we_d = 1'b1;
      end
      RUN: begin
        cpu_rst_d = 1'b0;
      end
      default: begin
        in_ready_d = 1'b0;
      end
    endcase
  end

  assign in_ready    = in_ready_q;
  assign imem_we     = we_q;
  assign imem_addr   = index_q;
  assign imem_wdata  = wdata_q;
  assign cpu_reset   = cpu_rst_q;
  assign finished    = fin_q;
  assign cycle_count = cc_q;
  assign err         = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load/run/halt, malformed streams, gapped
// valid, reset mid-run and cycle counter saturation (CW reduced to 4).
module tb_imem_loader;

  localparam int D  = 12;
  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          imem_we;
  logic [D-1:0]  imem_addr;
  logic [8:0]    imem_wdata;
  logic          cpu_reset;
  logic          cpu_done;
  logic          finished;
  logic [CW-1:0] cycle_count;
  logic          err;

  int errors = 0;
  int checks = 0;

  // write log captured from the DUT strobe
  logic [D-1:0] wr_addr [16];
  logic [8:0]   wr_data [16];
  int           wcount = 0;
  int           ready_in_wr = 0;

  imem_loader #(.D(D), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
    .cpu_done(cpu_done), .finished(finished), .cycle_count(cycle_count),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // record every write strobe cycle and any overlap of in_ready with a write
  always @(negedge clk) begin
    if (imem_we) begin
      if (wcount < 16) begin
        wr_addr[wcount] <= imem_addr;
        wr_data[wcount] <= imem_wdata;
      end
      wcount <= wcount + 1;
      if (in_ready) ready_in_wr <= ready_in_wr + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // present a byte and hold it until the loader takes it (bounded wait)
  task automatic send(input logic [7:0] b);
    int t;
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin
      tick();
      t++;
    end
    chk("send_timeout", {31'd0, (t < 20)}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = 8'hxx;
  endtask

  // same as send but with a random idle gap and junk data while invalid
  task automatic send_gap(input logic [7:0] b);
    int g;
    g = $urandom_range(0, 3);
    for (int i = 0; i < g; i++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom_range(0, 255));
      tick();
    end
    send(b);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    cpu_done = 1'b0;
    tick();
    tick();

    // reset state
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_imem_we",   {31'd0, imem_we},   32'd0);
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_finished",  {31'd0, finished},  32'd0);
    chk("rst_err",       {31'd0, err},       32'd0);
    chk("rst_cycles",    {28'd0, cycle_count}, 32'd0);

    reset = 1'b1;
    tick();
    chk("idle_in_ready", {31'd0, in_ready}, 32'd0);

    // normal load: N=2, words 0x1A5, 0x003
    pulse_start();
    chk("hdr_in_ready", {31'd0, in_ready}, 32'd1);
    send(8'h02);
    send(8'h00);
    send(8'hA5);
    send(8'h01);
    chk("wr0_we",   {31'd0, imem_we},    32'd1);
    chk("wr0_addr", {20'd0, imem_addr},  32'd0);
    chk("wr0_data", {23'd0, imem_wdata}, 32'h1A5);
    chk("wr0_rdy",  {31'd0, in_ready},   32'd0);
    send(8'h03);
    send(8'h00);
    chk("wr1_we",   {31'd0, imem_we},    32'd1);
    chk("wr1_addr", {20'd0, imem_addr},  32'd1);
    chk("wr1_data", {23'd0, imem_wdata}, 32'h003);
    chk("wr1_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    tick();
    chk("run_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    chk("run_we_low",    {31'd0, imem_we},   32'd0);
    chk("run_cycles0",   {28'd0, cycle_count}, 32'd0);
    chk("load_wcount",   32'(wcount), 32'd2);
    chk("log0_addr", {20'd0, wr_addr[0]}, 32'd0);
    chk("log0_data", {23'd0, wr_data[0]}, 32'h1A5);
    chk("log1_addr", {20'd0, wr_addr[1]}, 32'd1);
    chk("log1_data", {23'd0, wr_data[1]}, 32'h003);

    // four counting cycles, halt on the fifth
    repeat (4) tick();
    chk("run_cycles4", {28'd0, cycle_count}, 32'd4);
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    chk("fin_cycles",    {28'd0, cycle_count}, 32'd4);
    chk("fin_finished",  {31'd0, finished},    32'd1);
    chk("fin_cpu_reset", {31'd0, cpu_reset},   32'd1);
    repeat (3) tick();
    chk("fin_hold_cycles", {28'd0, cycle_count}, 32'd4);
    chk("fin_hold_fin",    {31'd0, finished},    32'd1);
    chk("fin_hold_rdy",    {31'd0, in_ready},    32'd0);

    // restart from FIN clears the sticky results
    pulse_start();
    chk("restart_fin",    {31'd0, finished},    32'd0);
    chk("restart_cycles", {28'd0, cycle_count}, 32'd0);
    chk("restart_rdy",    {31'd0, in_ready},    32'd1);

    // zero-length header
    send(8'h00);
    send(8'h00);
    chk("n0_err",       {31'd0, err},       32'd1);
    chk("n0_rdy",       {31'd0, in_ready},  32'd0);
    chk("n0_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("n0_wcount",    32'(wcount),        32'd2);

    // header high nibble nonzero
    pulse_start();
    chk("clr_err", {31'd0, err}, 32'd0);
    send(8'h05);
    send(8'h10);
    chk("hdrhi_err", {31'd0, err},      32'd1);
    chk("hdrhi_rdy", {31'd0, in_ready}, 32'd0);

    // bad instruction high byte
    pulse_start();
    send(8'h01);
    send(8'h00);
    send(8'h55);
    send(8'h02);
    chk("inshi_err",    {31'd0, err},       32'd1);
    chk("inshi_rdy",    {31'd0, in_ready},  32'd0);
    chk("inshi_we",     {31'd0, imem_we},   32'd0);
    tick();
    chk("inshi_wcount", 32'(wcount),        32'd2);
    chk("inshi_cpu_reset", {31'd0, cpu_reset}, 32'd1);

    // same program with gapped valid
    pulse_start();
    chk("gap_err_clr", {31'd0, err}, 32'd0);
    send_gap(8'h02);
    send_gap(8'h00);
    send_gap(8'hA5);
    send_gap(8'h01);
    send_gap(8'h03);
    send_gap(8'h00);
    tick();
    chk("gap_wcount", 32'(wcount), 32'd4);
    chk("gap0_addr", {20'd0, wr_addr[2]}, 32'd0);
    chk("gap0_data", {23'd0, wr_data[2]}, 32'h1A5);
    chk("gap1_addr", {20'd0, wr_addr[3]}, 32'd1);
    chk("gap1_data", {23'd0, wr_data[3]}, 32'h003);
    chk("rdy_in_wr", 32'(ready_in_wr), 32'd0);

    // reset in the middle of a run
    repeat (7) tick();
    chk("mid_cycles7",    {28'd0, cycle_count}, 32'd7);
    chk("mid_cpu_reset",  {31'd0, cpu_reset},   32'd0);
    reset    = 1'b0;
    start    = 1'b1;
    cpu_done = 1'b1;
    tick();
    chk("mrst_cycles",    {28'd0, cycle_count}, 32'd0);
    chk("mrst_finished",  {31'd0, finished},    32'd0);
    chk("mrst_cpu_reset", {31'd0, cpu_reset},   32'd1);
    chk("mrst_rdy",       {31'd0, in_ready},    32'd0);
    tick();
    chk("mrst_ignore_start", {31'd0, in_ready}, 32'd0);
    chk("mrst_ignore_done",  {31'd0, finished}, 32'd0);
    reset    = 1'b1;
    start    = 1'b0;
    cpu_done = 1'b0;
    tick();
    chk("post_rst_idle", {31'd0, in_ready}, 32'd0);

    // counter saturates at 2^CW-1
    pulse_start();
    send(8'h01);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    tick();
    chk("sat_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    repeat (20) tick();
    chk("sat_cycles", {28'd0, cycle_count}, 32'd15);
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    chk("sat_fin_cycles", {28'd0, cycle_count}, 32'd15);
    chk("sat_finished",   {31'd0, finished},    32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter D, default 12, meaning instruction address width (matches CPU program counter).
REQ-002 SHALL have parameter CW, default 16, meaning cycle counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begin load session (level sampled each cycle).
REQ-006 SHALL have port in_data  input  8  load stream byte.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  loader accepts byte this cycle.
REQ-009 SHALL have port imem_we  output  1  instruction memory write strobe.
REQ-010 SHALL have port imem_addr  output  D  instruction memory write address.
REQ-011 SHALL have port imem_wdata  output  9  machine code word.
REQ-012 SHALL have port cpu_reset  output  1  active-high hold-in-reset to CPU.
REQ-013 SHALL have port cpu_done  input  1  CPU halt indication.
REQ-014 SHALL have port finished  output  1  run complete, sticky until next session.
REQ-015 SHALL have port cycle_count  output  CW  CPU run cycles.
REQ-016 SHALL have port err  output  1  malformed stream, sticky until next session.

Function
REQ-017 SHALL implement states IDLE, HDR_LO, HDR_HI, INS_LO, INS_HI, WR, RUN, FIN.
REQ-018 SHALL accept a byte only when in_valid and in_ready are both 1; in_ready SHALL be 1 exactly in HDR_LO, HDR_HI, INS_LO, INS_HI.
REQ-019 SHALL, on start=1 in IDLE or FIN, clear finished, err, cycle_count, word index, and go to HDR_LO; start SHALL be ignored in all other states.
REQ-020 SHALL form instruction count N = {HDR_HI[3:0], HDR_LO}; HDR_LO byte -> HDR_HI.
REQ-021 SHALL, on HDR_HI byte with bits [7:4] nonzero or N==0, set err and go to IDLE; otherwise go to INS_LO with index=0.
REQ-022 SHALL, on INS_LO byte, latch it as wdata[7:0] and go to INS_HI.
REQ-023 SHALL, on INS_HI byte, go to IDLE with err set and no write if bits [7:1] nonzero; otherwise latch bit 0 as wdata[8] and go to WR.
REQ-024 SHALL, in WR, assert imem_we for exactly one cycle with imem_addr=index and imem_wdata valid in that cycle; imem_we SHALL be 0 in every other state.
REQ-025 SHALL leave WR to RUN if index==N-1, else increment index and go to INS_LO.
REQ-026 SHALL drive cpu_reset=0 only in RUN; cpu_reset=1 in all other states.
REQ-027 SHALL, in RUN with cpu_done=0, increment cycle_count by 1, saturating at 2^CW-1 (no wrap).
REQ-028 SHALL, in RUN with cpu_done=1, not increment, set finished=1 and go to FIN.
REQ-029 SHALL hold cycle_count, finished and err stable in IDLE and FIN.
REQ-030 SHALL bound N by 2^D-1; index SHALL never wrap within a session.

Reset
REQ-031 SHALL, when reset=0 at a rising edge, enter IDLE, clear index, wdata, cycle_count, finished, err, imem_we, in_ready, and set cpu_reset=1, regardless of current state including mid-load or mid-run.
REQ-032 SHALL ignore start, in_valid and cpu_done while reset=0.

Verification
REQ-033 Bench SHALL load N=2, words 0x1A5 and 0x003 (bytes 02,00,A5,01,03,00) -> two single-cycle imem_we pulses: addr 0 data 0x1A5, addr 1 data 0x003; cpu_reset falls the cycle after the second write.
REQ-034 Bench SHALL hold cpu_done=1 on the 5th RUN cycle -> cycle_count=4, finished=1, cpu_reset=1, FIN held until start.
REQ-035 Bench SHALL send header bytes 00,00 -> err=1, state IDLE, no imem_we, cpu_reset=1.
REQ-036 Bench SHALL send instruction high byte 0x02 -> err=1, no write for that word, return to IDLE.
REQ-037 Bench SHALL toggle in_valid randomly during load -> identical writes as with continuous valid; in_ready=0 during WR.
REQ-038 Bench SHALL assert reset=0 mid-RUN with cycle_count=7 -> next edge: cycle_count=0, finished=0, cpu_reset=1, state IDLE.
